// File: rtl/core_pkg.sv
// Types and constants shared by the core pipeline stages.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, inst} between instruction fetch and decode.
module fetch_buf
    import core_pkg::*;
#(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_inst,
    input  logic              pop,
    input  logic              flush,
    output logic              valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_inst,
    output logic [1:0]        count
);
    logic [ADDR_W-1:0] pc_q   [2];
    logic [DATA_W-1:0] inst_q [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        cnt;
    logic              do_pop;

    assign do_pop    = pop && (cnt != 2'd0);
    assign valid     = (cnt != 2'd0);
    assign head_pc   = pc_q[rd_ptr];
    assign head_inst = inst_q[rd_ptr];
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]   <= push_pc;
                inst_q[wr_ptr] <= push_inst;
                wr_ptr         <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding imem read, results queued for decode,
// flush-aware (a request that cannot be withdrawn is drained and dropped).
module if_fetch
    import core_pkg::*;
#(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = XLEN
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_EN,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_flush,
    output logic              o_pc_en,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic              o_inst_valid,
    output logic [DATA_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    input  logic              i_inst_ready
);
    fetch_state_e      state, state_nxt;
    logic              req_q;
    logic [ADDR_W-1:0] req_pc;
    logic              pend_q, pend_nxt;
    logic              issue, push, pc_en;
    logic [1:0]        count;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: if (i_EN && !i_flush && count < 2'd2 && !pend_q) begin
                issue     = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                if (i_imem_ack) begin
                    push      = !i_flush;
                    state_nxt = IDLE;
                end else if (i_flush) begin
                    state_nxt = DROP;
                end
            end
            DROP: if (i_imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A word accepted while disabled still owes the PC its advance pulse;
        // a flush makes that owed advance moot.
        pc_en    = !i_RST && !i_flush && i_EN && (push || pend_q);
        pend_nxt = pend_q;
        if (i_flush)
            pend_nxt = 1'b0;
        else if (push && !i_EN)
            pend_nxt = 1'b1;
        else if (pc_en)
            pend_nxt = 1'b0;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            req_pc <= '0;
            pend_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend_q <= pend_nxt;
            if (issue) begin
                req_q  <= 1'b1;
                req_pc <= i_pc;
            end else if (i_imem_ack) begin
                req_q  <= 1'b0;
            end
        end
    end

    assign o_pc_en     = pc_en;
    assign o_imem_req  = req_q;
    assign o_imem_addr = req_pc;

    fetch_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
        .clk       (i_CLK),
        .rst       (i_RST),
        .push      (push),
        .push_pc   (req_pc),
        .push_inst (i_imem_rdata),
        .pop       (i_inst_ready),
        .flush     (i_flush),
        .valid     (o_inst_valid),
        .head_pc   (o_inst_pc),
        .head_inst (o_inst),
        .count     (count)
    );
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage directly downstream of the PC register. It takes the current PC and issues one instruction-memory read at a time using a req/ack handshake. Each returned word is buffered with its PC in a 2-entry queue that feeds decode through a valid/ready handshake. It pulses the PC's enable to advance it, and discards in-flight and buffered work when a redirect (flush) occurs.

Parameters:
ADDR_W, 32, PC / instruction-memory address width
DATA_W, 32, instruction word width

Ports:
i_CLK  in  1  clock, all logic on rising edge
i_RST  in  1  reset, synchronous, active-high
i_EN  in  1  core enable; low = issue no new requests
i_pc  in  ADDR_W  current PC from the PC register
i_flush  in  1  redirect; asserted in the same cycle as the PC's pc_set
o_pc_en  out  1  one-cycle pulse to the PC's enable, advancing it by one instruction
o_imem_req  out  1  memory read request, held until ack
o_imem_addr  out  ADDR_W  request address, stable while req high
i_imem_ack  in  1  read data valid, single cycle
i_imem_rdata  in  DATA_W  read data
o_inst_valid  out  1  buffer head valid
o_inst  out  DATA_W  head instruction
o_inst_pc  out  ADDR_W  PC of head instruction
i_inst_ready  in  1  decode accepts head

Behaviour:
- Reset (i_RST=1 at the clock edge):
  - all outputs 0
  - state IDLE
  - buffer count 0
  - i_RST overrides every other input, including a request outstanding mid-operation (memory model is reset together with the core).
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, result kept.
  - DROP: request outstanding, result discarded.
- IDLE -> REQ when i_EN=1, i_flush=0 and count<2.
  - Register o_imem_addr=i_pc, req_pc=i_pc, o_imem_req=1; visible the cycle after the decision.
- REQ:
  - o_imem_req stays high and o_imem_addr stays unchanged until i_imem_ack.
  - On ack with i_flush=0: push {req_pc, i_imem_rdata}; o_pc_en=1 for exactly that cycle; o_imem_req=0; go to IDLE.
  - The next issue uses the updated i_pc, so peak throughput is 1 instruction per 2 cycles plus memory latency.
- REQ with i_flush=1 and no ack: go to DROP, keep o_imem_req high; the bus protocol forbids withdrawing a request.
- REQ with i_flush=1 and ack in the same cycle: data discarded, no o_pc_en, go to IDLE.
- DROP:
  - On ack: discard data, o_imem_req=0, go to IDLE.
  - A further flush while in DROP stays in DROP.
- o_pc_en is never asserted in a cycle where i_flush=1 or i_EN=0.
  - If an ack arrives with i_EN=0, data is still pushed, but the pulse is deferred until the first cycle with i_EN=1; IDLE does not issue before that pulse.
- Flush in any state:
  - Buffer count -> 0 at the next edge.
  - o_inst_valid=0 the next cycle.
  - No issue in the flush cycle.
  - First post-flush request is issued from the redirected i_pc, one cycle after flush drops (IDLE) or after the DROP ack.
- Buffer:
  - 2-entry FIFO; o_inst_valid = (count!=0); o_inst/o_inst_pc show the head.
  - Pop when o_inst_valid & i_inst_ready.
  - Push and pop in the same cycle leaves count unchanged and preserves order.
  - Pointers wrap modulo 2.
- Full: issue requires count<2 at issue time. Pops only lower the count, so an ack always finds space and overflow is impossible. At count=2 the stage idles with o_imem_req=0.
- Empty: o_inst_valid=0; i_inst_ready is ignored; o_inst/o_inst_pc hold their last values (don't-care).
- Address arithmetic is not performed here; the PC register owns increment and wrap-around.

Decomposition:
- Shared package core_pkg:
  - XLEN=32
  - fetch state enum {IDLE, REQ, DROP}
  - NOP encoding 32'h00000013 for decode-side bubbles
- One sub-module: fetch_buf, a 2-entry FIFO of {pc, inst} with push/pop/flush/count.

Test Plan:
- Reset, then i_EN=1 with i_pc=0x00 and memory latency 1 returning 0xA0 -> req addr 0x00; on ack o_pc_en pulses once; o_inst_valid=1 with o_inst=0xA0, o_inst_pc=0x00.
- i_inst_ready=0, sequential PCs 0x00/0x04/0x08 -> exactly 2 entries buffered, o_imem_req stays 0. Then ready=1 -> pops in order 0x00, 0x04, then the request for 0x08 issues.
- Flush with memory latency 3 while REQ for 0x04 is pending, pc redirected to 0x56 -> o_imem_req held until ack, data dropped, no o_pc_en, next request addr=0x56, buffer empty after flush.
- Flush coincident with ack -> no push, no o_pc_en, next request addr is the redirect target.
- Simultaneous push and pop at count=1 -> count stays 1, FIFO order is correct across pointer wrap over 6 instructions.
- i_RST=1 mid-REQ -> all outputs 0 next cycle; after release, the first request uses i_pc.
